// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
// Shares the register file's single write port between the in-order
// pipeline writeback and a long-latency unit (LLU). LLU results wait in a
// small FIFO and drain into cycles the pipeline leaves free. A 32-bit
// scoreboard tracks registers with an outstanding LLU write. Decode is
// stalled on RAW/WAW hazards, and also when the FIFO head has been starved
// for STARVE_LIMIT cycles.
//
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_wb_*                 pipeline writeback (valid/rd/data), no backpressure
//   i_dec_*                decode-stage operands checked against the scoreboard
//   i_llu_issue*           LLU op issue (sets scoreboard bit), ignored while stalled
//   i_llu_valid/rd/data    LLU result, accepted when o_llu_ready
//   o_llu_ready            FIFO not full
//   o_rd_wen/waddr/wdata   register-file write port
//   o_busy                 scoreboard, bit n = LLU write to xn outstanding
//   o_pipe_stall           decode must hold
module rf_wb_arbiter #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wb_valid,
    input  logic [4:0]  i_wb_rd,
    input  logic [31:0] i_wb_data,
    input  logic        i_dec_valid,
    input  logic [4:0]  i_dec_rs1,
    input  logic [4:0]  i_dec_rs2,
    input  logic [4:0]  i_dec_rd,
    input  logic        i_llu_issue,
    input  logic [4:0]  i_llu_issue_rd,
    input  logic        i_llu_valid,
    output logic        o_llu_ready,
    input  logic [4:0]  i_llu_rd,
    input  logic [31:0] i_llu_data,
    output logic        o_rd_wen,
    output logic [4:0]  o_rd_waddr,
    output logic [31:0] o_rd_wdata,
    output logic [31:0] o_busy,
    output logic        o_pipe_stall
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Result storage carries no reset; validity comes from count_q alone.
    logic [4:0]       fifo_rd_q   [FIFO_DEPTH];
    logic [31:0]      fifo_data_q [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [3:0]       starve_q, starve_d;
    logic [31:0]      busy_q, busy_d;

    logic empty, full, wb_take, pop, push, haz, starve, issue_ok;

    // Port arbitration and hazard detection
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CNT_W'(FIFO_DEPTH));
        // A pipeline write to x0 is a no-op and leaves the port to the FIFO.
        wb_take  = i_wb_valid && (i_wb_rd != 5'd0);
        pop      = !wb_take && !empty;
        push     = i_llu_valid && !full && (i_llu_rd != 5'd0);

        haz      = i_dec_valid &&
                   (busy_q[i_dec_rs1] || busy_q[i_dec_rs2] || busy_q[i_dec_rd]);
        starve   = (starve_q == 4'(STARVE_LIMIT));
        // Stall looks only at registered busy bits: a drain this cycle
        // releases decode one cycle later.
        o_pipe_stall = haz || starve;
        issue_ok     = i_llu_issue && !o_pipe_stall && (i_llu_issue_rd != 5'd0);

        // Ready ignores a same-cycle pop to keep it off the writeback path.
        o_llu_ready = !full;
        o_busy      = busy_q;

        o_rd_wen   = 1'b0;
        o_rd_waddr = 5'd0;
        o_rd_wdata = 32'd0;
        if (wb_take) begin
            o_rd_wen   = 1'b1;
            o_rd_waddr = i_wb_rd;
            o_rd_wdata = i_wb_data;
        end else if (!empty) begin
            o_rd_wen   = 1'b1;
            o_rd_waddr = fifo_rd_q[rd_ptr_q];
            o_rd_wdata = fifo_data_q[rd_ptr_q];
        end
    end

    // Next-state for FIFO control, starvation counter and scoreboard
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

        // Non-empty without a pop means the head lost the port to the pipeline.
        starve_d = starve_q;
        if (empty || pop) begin
            starve_d = 4'd0;
        end else if (!starve) begin
            starve_d = starve_q + 4'd1;
        end

        // Clear is applied first so that a simultaneous set of the same
        // register wins.
        busy_d = busy_q;
        if (pop) begin
            busy_d[fifo_rd_q[rd_ptr_q]] = 1'b0;
        end
        if (issue_ok) begin
            busy_d[i_llu_issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= 4'd0;
            busy_q   <= 32'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            busy_q   <= busy_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q]   <= i_llu_rd;
            fifo_data_q[wr_ptr_q] <= i_llu_data;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wbv;
    logic [4:0]  wbrd;
    logic [31:0] wbdata;
    logic        decv;
    logic [4:0]  rs1, rs2, drd;
    logic        iss;
    logic [4:0]  issrd;
    logic        lv;
    logic        lready;
    logic [4:0]  lrd;
    logic [31:0] ldata;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] busy;
    logic        stall;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_wb_valid(wbv), .i_wb_rd(wbrd), .i_wb_data(wbdata),
        .i_dec_valid(decv), .i_dec_rs1(rs1), .i_dec_rs2(rs2), .i_dec_rd(drd),
        .i_llu_issue(iss), .i_llu_issue_rd(issrd),
        .i_llu_valid(lv), .o_llu_ready(lready), .i_llu_rd(lrd), .i_llu_data(ldata),
        .o_rd_wen(wen), .o_rd_waddr(waddr), .o_rd_wdata(wdata),
        .o_busy(busy), .o_pipe_stall(stall)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: queue of pending {rd,data}, busy register set,
    // count of consecutive blocked cycles.
    logic [36:0] mq[$];
    logic [31:0] mbusy;
    int          mstarve;
    logic        last_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic idle();
        rst = 1'b0; wbv = 1'b0; wbrd = 5'd0; wbdata = 32'd0;
        decv = 1'b0; rs1 = 5'd0; rs2 = 5'd0; drd = 5'd0;
        iss = 1'b0; issrd = 5'd0; lv = 1'b0; lrd = 5'd0; ldata = 32'd0;
    endtask

    // Called just after a falling edge with inputs already set: checks every
    // output against the model, then advances the model across the rising edge.
    task automatic cycle();
        logic        take, e_wen, e_rdy, e_haz, e_stall, pop, acc;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        #1;
        take   = wbv && (wbrd != 5'd0);
        e_wen  = 1'b0;
        e_addr = 5'd0;
        e_data = 32'd0;
        if (take) begin
            e_wen = 1'b1; e_addr = wbrd; e_data = wbdata;
        end else if (mq.size() > 0) begin
            e_wen = 1'b1; e_addr = mq[0][36:32]; e_data = mq[0][31:0];
        end
        e_rdy   = (mq.size() < DEPTH);
        e_haz   = decv && (mbusy[rs1] || mbusy[rs2] || mbusy[drd]);
        e_stall = e_haz || (mstarve == LIMIT);
        chk("wen",   32'(wen),   32'(e_wen));
        chk("waddr", 32'(waddr), 32'(e_addr));
        chk("wdata", wdata,      e_data);
        chk("ready", 32'(lready), 32'(e_rdy));
        chk("busy",  busy,       mbusy);
        chk("stall", 32'(stall), 32'(e_stall));
        last_stall = e_stall;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            mbusy   = 32'd0;
            mstarve = 0;
        end else begin
            pop = !take && (mq.size() > 0);
            acc = lv && e_rdy && (lrd != 5'd0);
            if (mq.size() == 0 || pop) mstarve = 0;
            else if (mstarve < LIMIT)  mstarve++;
            if (pop) begin
                mbusy[mq[0][36:32]] = 1'b0;
                void'(mq.pop_front());
            end
            if (iss && !e_stall && issrd != 5'd0) mbusy[issrd] = 1'b1;
            if (acc) mq.push_back({lrd, ldata});
        end
        @(negedge clk);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        mbusy = 32'd0; mstarve = 0; last_stall = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state, idle
        #1;
        chk("rst_wen",   32'(wen),    32'd0);
        chk("rst_busy",  busy,        32'd0);
        chk("rst_ready", 32'(lready), 32'd1);
        chk("rst_stall", 32'(stall),  32'd0);
        cycle();

        // Pipeline write and LLU result in the same cycle
        idle(); wbv = 1'b1; wbrd = 5'd5; wbdata = 32'hAAAA0000;
        lv = 1'b1; lrd = 5'd7; ldata = 32'h12345678;
        #1; chk("same_wb_addr", 32'(waddr), 32'd5);
        cycle();
        idle();
        #1;
        chk("llu_wen",  32'(wen),   32'd1);
        chk("llu_addr", 32'(waddr), 32'd7);
        chk("llu_data", wdata,      32'h12345678);
        cycle();
        idle(); cycle();

        // RAW hazard on x9
        idle(); iss = 1'b1; issrd = 5'd9; cycle();
        idle(); decv = 1'b1; rs2 = 5'd9;
        #1; chk("raw_stall", 32'(stall), 32'd1);
        cycle();
        lv = 1'b1; lrd = 5'd9; ldata = 32'h00000999; cycle();
        lv = 1'b0;
        #1;
        chk("raw_pop_addr",  32'(waddr), 32'd9);
        chk("raw_pop_stall", 32'(stall), 32'd1);
        cycle();
        #1;
        chk("raw_busy9", 32'(busy[9]), 32'd0);
        chk("raw_release", 32'(stall), 32'd0);
        cycle();
        // WAW hazard on x9
        idle(); iss = 1'b1; issrd = 5'd9; cycle();
        idle(); decv = 1'b1; drd = 5'd9;
        #1; chk("waw_stall", 32'(stall), 32'd1);
        cycle();
        idle(); lv = 1'b1; lrd = 5'd9; ldata = 32'h9; cycle();
        idle(); cycle(); cycle();

        // Starvation with a full FIFO
        idle(); wbv = 1'b1; wbrd = 5'd1; wbdata = 32'h1;
        lv = 1'b1; lrd = 5'd3; ldata = 32'h33; cycle();
        lrd = 5'd4; ldata = 32'h44; cycle();
        lrd = 5'd5; ldata = 32'h55;
        #1; chk("full_ready", 32'(lready), 32'd0);
        cycle();
        lv = 1'b0; cycle();
        #1; chk("starve_early", 32'(stall), 32'd0);
        cycle();
        #1; chk("starve_stall", 32'(stall), 32'd1);
        cycle();
        wbv = 1'b0;
        #1;
        chk("starve_drain_addr", 32'(waddr), 32'd3);
        chk("starve_drain_data", wdata,      32'h33);
        cycle();
        #1; chk("starve_ready_back", 32'(lready), 32'd1);
        cycle();
        idle(); cycle(); cycle();

        // rd = 0 on issue and result
        idle(); iss = 1'b1; issrd = 5'd0; lv = 1'b1; lrd = 5'd0; ldata = 32'hDEAD;
        cycle();
        idle();
        #1;
        chk("x0_busy",  busy,        32'd0);
        chk("x0_wen",   32'(wen),    32'd0);
        chk("x0_ready", 32'(lready), 32'd1);
        cycle();

        // Reset with buffered entries and busy bits
        idle(); iss = 1'b1; issrd = 5'd2; cycle();
        issrd = 5'd3; cycle();
        idle(); wbv = 1'b1; wbrd = 5'd1; lv = 1'b1; lrd = 5'd2; ldata = 32'h22; cycle();
        lrd = 5'd3; ldata = 32'h33; cycle();
        idle(); rst = 1'b1; wbv = 1'b1; wbrd = 5'd1; cycle();
        idle();
        #1;
        chk("mid_rst_wen",   32'(wen),    32'd0);
        chk("mid_rst_busy",  busy,        32'd0);
        chk("mid_rst_ready", 32'(lready), 32'd1);
        cycle();

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            rst    = ($urandom_range(0, 199) == 0);
            wbv    = last_stall ? 1'b0 : ($urandom_range(0, 2) != 0);
            wbrd   = 5'($urandom_range(0, 7));
            wbdata = $urandom;
            decv   = 1'($urandom_range(0, 1));
            rs1    = 5'($urandom_range(0, 7));
            rs2    = 5'($urandom_range(0, 7));
            drd    = 5'($urandom_range(0, 7));
            iss    = ($urandom_range(0, 3) == 0);
            issrd  = 5'($urandom_range(0, 7));
            lv     = 1'($urandom_range(0, 1));
            lrd    = 5'($urandom_range(0, 7));
            ldata  = $urandom;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
